// File: rtl/hs_link_arbiter_pkg.sv
// Shared types and defaults for the round-robin 4-phase link arbiter.
package hs_pkg;

  localparam int NUM_SRC_DEF = 4;
  localparam int DATA_W_DEF  = 6;
  localparam int TIMEOUT_DEF = 15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    ACK  = 2'd2,
    REL  = 2'd3
  } state_e;

  // Modulo-n increment, used to move the round-robin pointer past the last grantee.
  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/hs_link_arbiter_if.sv
// Sender-side and receiver-side handshake signals of the shared link.
interface hs_link_arbiter_if #(
  parameter int NUM_SRC = 4,
  parameter int DATA_W  = 6
);

  logic [NUM_SRC-1:0]        src_req;
  logic [NUM_SRC*DATA_W-1:0] src_data;
  logic [NUM_SRC-1:0]        src_ack;
  logic                      link_req;
  logic [DATA_W-1:0]         link_data;
  logic                      link_ack;

  // master: the arbiter itself; slave: the senders and receiver around it.
  modport master (
    input  src_req, src_data, link_ack,
    output src_ack, link_req, link_data
  );

  modport slave (
    output src_req, src_data, link_ack,
    input  src_ack, link_req, link_data
  );

endinterface

// File: rtl/hs_link_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_picker #(
  parameter int N    = 4,
  parameter int ID_W = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] ptr,
  output logic            valid,
  output logic [ID_W-1:0] index
);

  logic [2*N-1:0] dbl;

  // Rotating the doubled vector by ptr puts the highest-priority request at bit 0.
  always_comb begin
    dbl   = {req, req} >> ptr;
    valid = |req;
    index = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (dbl[i]) index = ID_W'((int'(ptr) + i) % N);
    end
  end

endmodule

// File: rtl/hs_link_arbiter.sv
// Round-robin arbiter sharing one 4-phase req/ack link among NUM_SRC senders, with watchdog abort.
module hs_link_arbiter
  import hs_pkg::*;
#(
  parameter int NUM_SRC = NUM_SRC_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ID_W    = $clog2(NUM_SRC),
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic                   clk,
  input  logic                   clr,
  hs_link_arbiter_if.master      bus,
  output logic [ID_W-1:0]        grant_id,
  output logic                   busy,
  output logic                   timeout_err
);

  state_e               state_q, state_d;
  logic [ID_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic [7:0]           wdog_q, wdog_d;
  logic [ID_W-1:0]      grant_q, grant_d;
  logic [DATA_W-1:0]    data_q, data_d;
  logic                 link_req_q, link_req_d;
  logic [NUM_SRC-1:0]   src_ack_q, src_ack_d;
  logic                 busy_q, busy_d;
  logic                 tmo_q, tmo_d;

  logic                 pick_valid;
  logic [ID_W-1:0]      pick_idx;
  logic [NUM_SRC-1:0]   grant_mask;
  logic [ID_W-1:0]      ptr_after_grant;

  rr_picker #(.N(NUM_SRC), .ID_W(ID_W)) u_picker (
    .req   (bus.src_req),
    .ptr   (rr_ptr_q),
    .valid (pick_valid),
    .index (pick_idx)
  );

  assign grant_mask      = NUM_SRC'(1) << grant_q;
  assign ptr_after_grant = ID_W'(wrap_inc(int'(grant_q), NUM_SRC));

  // NOTE: every signal assigned here gets a default first so no latch is inferred.
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    wdog_d     = wdog_q;
    grant_d    = grant_q;
    data_d     = data_q;
    link_req_d = link_req_q;
    src_ack_d  = src_ack_q;
    busy_d     = busy_q;
    tmo_d      = 1'b0;

    unique case (state_q)
      IDLE: begin
        // A receiver still holding ack from a previous transfer must release first.
        if (pick_valid && !bus.link_ack) begin
          grant_d    = pick_idx;
          data_d     = DATA_W'(bus.src_data >> (int'(pick_idx) * DATA_W));
          link_req_d = 1'b1;
          busy_d     = 1'b1;
          wdog_d     = '0;
          state_d    = REQ;
        end
      end
      REQ: begin
        wdog_d = wdog_q + 8'd1;
        if (bus.link_ack) begin
          link_req_d = 1'b0;
          src_ack_d  = grant_mask;
          state_d    = ACK;
        end else if (wdog_q == 8'(TIMEOUT - 1)) begin
          link_req_d = 1'b0;
          tmo_d      = 1'b1;
          rr_ptr_d   = ptr_after_grant;
          state_d    = REL;
        end
      end
      ACK: begin
        if (!bus.link_ack && !(|(bus.src_req & grant_mask))) begin
          src_ack_d = '0;
          rr_ptr_d  = ptr_after_grant;
          busy_d    = 1'b0;
          state_d   = IDLE;
        end
      end
      REL: begin
        if (!bus.link_ack) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      wdog_q     <= '0;
      grant_q    <= '0;
      data_q     <= '0;
      link_req_q <= 1'b0;
      src_ack_q  <= '0;
      busy_q     <= 1'b0;
      tmo_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      wdog_q     <= wdog_d;
      grant_q    <= grant_d;
      data_q     <= data_d;
      link_req_q <= link_req_d;
      src_ack_q  <= src_ack_d;
      busy_q     <= busy_d;
      tmo_q      <= tmo_d;
    end
  end

  assign bus.link_req  = link_req_q;
  assign bus.link_data = data_q;
  assign bus.src_ack   = src_ack_q;
  assign grant_id      = grant_q;
  assign busy          = busy_q;
  assign timeout_err   = tmo_q;

endmodule

// File: tb/tb_hs_link_arbiter.sv
// Directed bench for hs_link_arbiter: reset, single transfer, round-robin, timeout, stale ack, mid-transfer reset.
module tb_hs_link_arbiter;

  localparam int NUM_SRC = 4;
  localparam int DATA_W  = 6;
  localparam int ID_W    = 2;
  localparam int TIMEOUT = 15;

  logic            clk = 1'b0;
  logic            clr;
  logic [ID_W-1:0] grant_id;
  logic            busy;
  logic            timeout_err;

  int total = 0;
  int bad   = 0;

  hs_link_arbiter_if #(.NUM_SRC(NUM_SRC), .DATA_W(DATA_W)) bus ();

  hs_link_arbiter #(
    .NUM_SRC (NUM_SRC),
    .DATA_W  (DATA_W),
    .ID_W    (ID_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk         (clk),
    .clr         (clr),
    .bus         (bus),
    .grant_id    (grant_id),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    clr = 1'b1;
    tick();
    tick();
    clr = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    logic [ID_W-1:0] rr_exp [5];
    rr_exp = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

    clr          = 1'b1;
    bus.src_req  = '0;
    bus.link_ack = 1'b0;
    bus.src_data = {6'h33, 6'h2A, 6'h15, 6'h0C};
    @(negedge clk);

    // 1. Reset with all senders requesting
    bus.src_req = 4'b1111;
    do_reset();
    check("rst_link_req", 32'(bus.link_req), 32'd0);
    check("rst_link_data", 32'(bus.link_data), 32'h00);
    check("rst_src_ack", 32'(bus.src_ack), 32'h0);
    check("rst_grant_id", 32'(grant_id), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_timeout_err", 32'(timeout_err), 32'd0);
    tick();
    check("first_grant_id", 32'(grant_id), 32'd0);
    check("first_link_req", 32'(bus.link_req), 32'd1);
    check("first_link_data", 32'(bus.link_data), 32'h0C);

    // 3. Round-robin: each sender drops then re-requests after its ack
    for (int k = 0; k < 5; k++) begin
      if (k > 0) begin
        bus.src_req = 4'b1111;
        tick();
      end
      check($sformatf("rr_grant_%0d", k), 32'(grant_id), 32'(rr_exp[k]));
      check($sformatf("rr_req_%0d", k), 32'(bus.link_req), 32'd1);
      bus.link_ack = 1'b1;
      tick();
      check($sformatf("rr_ack_%0d", k), 32'(bus.src_ack), 32'(4'b0001 << rr_exp[k]));
      bus.link_ack = 1'b0;
      bus.src_req  = 4'b1111 & ~(4'b0001 << rr_exp[k]);
      tick();
      check($sformatf("rr_release_%0d", k), 32'({busy, bus.src_ack}), 32'h0);
    end
    bus.src_req = '0;

    // 2. Single transfer from sender 2, receiver acks two cycles after link_req
    do_reset();
    bus.src_req = 4'b0100;
    tick();
    check("single_link_req", 32'(bus.link_req), 32'd1);
    check("single_link_data", 32'(bus.link_data), 32'h2A);
    check("single_grant", 32'(grant_id), 32'd2);
    check("single_no_early_ack", 32'(bus.src_ack), 32'h0);
    tick();
    check("single_wait_ack", 32'({bus.link_req, bus.src_ack}), 32'h10);
    bus.link_ack = 1'b1;
    tick();
    check("single_src_ack", 32'(bus.src_ack), 32'b0100);
    check("single_link_req_low", 32'(bus.link_req), 32'd0);
    bus.link_ack = 1'b0;
    tick();
    check("single_ack_held", 32'(bus.src_ack), 32'b0100);
    bus.src_req = 4'b0000;
    tick();
    check("single_ack_clear", 32'({busy, bus.src_ack}), 32'h0);
    bus.src_req = 4'b1001;
    tick();
    check("single_next_ptr3", 32'(grant_id), 32'd3);
    check("single_next_data", 32'(bus.link_data), 32'h33);

    // 4. Timeout: sender 1, receiver never acks
    bus.src_req = '0;
    do_reset();
    bus.src_req = 4'b0010;
    tick();
    check("tmo_start", 32'({bus.link_req, grant_id}), 32'h5);
    for (int c = 1; c < TIMEOUT; c++) begin
      tick();
      check($sformatf("tmo_hold_%0d", c), 32'({bus.link_req, timeout_err}), 32'h2);
    end
    bus.src_req = 4'b0110;
    tick();
    check("tmo_link_req_fall", 32'(bus.link_req), 32'd0);
    check("tmo_err_pulse", 32'(timeout_err), 32'd1);
    check("tmo_no_src_ack", 32'(bus.src_ack), 32'h0);
    check("tmo_busy_rel", 32'(busy), 32'd1);
    tick();
    check("tmo_err_cleared", 32'(timeout_err), 32'd0);
    check("tmo_idle", 32'({busy, bus.link_req}), 32'h0);
    tick();
    check("tmo_next_grant", 32'(grant_id), 32'd2);
    check("tmo_next_req", 32'(bus.link_req), 32'd1);

    // 5. Stale ack blocks granting
    bus.src_req = '0;
    do_reset();
    bus.link_ack = 1'b1;
    bus.src_req  = 4'b0010;
    for (int c = 0; c < 3; c++) begin
      tick();
      check($sformatf("stale_blocked_%0d", c), 32'({busy, bus.link_req}), 32'h0);
    end
    bus.link_ack = 1'b0;
    tick();
    check("stale_grant", 32'({bus.link_req, grant_id}), 32'h5);

    // 6. Reset while in ACK
    bus.src_req = '0;
    do_reset();
    bus.src_req = 4'b0100;
    tick();
    bus.link_ack = 1'b1;
    tick();
    check("midrst_in_ack", 32'(bus.src_ack), 32'b0100);
    clr = 1'b1;
    tick();
    check("midrst_src_ack", 32'(bus.src_ack), 32'h0);
    check("midrst_link_req", 32'(bus.link_req), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    clr          = 1'b0;
    bus.link_ack = 1'b0;
    bus.src_req  = 4'b1111;
    tick();
    check("midrst_ptr0_grant", 32'({bus.link_req, grant_id}), 32'h4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
